// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two requester handshakes and the register-file write port
// served by regfile_write_arbiter. The slave side is the arbiter itself; the
// master side is whoever produces requests and observes the write port.
interface regfile_write_arbiter_if;
    // Requester A (ALU / R-type writeback)
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    // Requester B (load / memory writeback)
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    // Register file write port and status
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        pending;

    modport slave (
        input  a_valid, a_reg, a_data,
        input  b_valid, b_reg, b_data,
        output a_ready, b_ready,
        output rf_we, rf_waddr, rf_wdata,
        output busy, pending
    );

    modport master (
        output a_valid, a_reg, a_data,
        output b_valid, b_reg, b_data,
        input  a_ready, b_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  busy, pending
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between requester A (index 0)
// and requester B (index 1). After reset it optionally zeroes registers
// 1..31, then drains two small FIFOs with round-robin arbitration on
// contention. The write port is fully registered.
module regfile_write_arbiter #(
    parameter int DEPTH    = 2,
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    regfile_write_arbiter_if.slave    bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 37;  // {reg[4:0], data[31:0]}

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [4:0]     r_clr_cnt;
    logic           r_rr;          // 0 = A has priority on the next contended grant
    logic           r_rf_we;
    logic [4:0]     r_rf_waddr;
    logic [31:0]    r_rf_wdata;

    logic           w_run;
    logic           w_busy;
    logic           w_a_ready;
    logic           w_b_ready;
    logic           w_contended;
    logic [1:0]     w_valid;
    logic [1:0]     w_push;
    logic [1:0]     w_pop;
    logic [1:0]     w_full;
    logic [1:0]     w_empty;
    logic [EW-1:0]  w_in   [2];
    logic [EW-1:0]  w_head [2];
    logic [EW-1:0]  w_grant_entry;

    assign w_run    = (r_state == S_RUN);
    assign w_valid  = {bus.b_valid, bus.a_valid};
    assign w_in[0]  = {bus.a_reg, bus.a_data};
    assign w_in[1]  = {bus.b_reg, bus.b_data};
    // Ready depends only on occupancy, so a push is simply valid && ready.
    assign w_push   = w_valid & {w_b_ready, w_a_ready};

    // One FIFO per requester. Pointers carry an extra wrap bit so full and
    // empty can be told apart when the index bits match.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_fifo
        logic [EW-1:0] r_mem [DEPTH];
        logic [PW-1:0] r_wptr;
        logic [PW-1:0] r_rptr;

        assign w_empty[gi] = (r_wptr == r_rptr);
        assign w_full[gi]  = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                             (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        assign w_head[gi]  = r_mem[r_rptr[AW-1:0]];

        // Storage write; contents need no reset because the pointers gate them.
        always_ff @(posedge clk) begin
            if (w_push[gi]) begin
                r_mem[r_wptr[AW-1:0]] <= w_in[gi];
            end
        end

        // Pointer update; reset flushes whatever was queued.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push[gi]) begin
                    r_wptr <= r_wptr + PW'(1);
                end
                if (w_pop[gi]) begin
                    r_rptr <= r_rptr + PW'(1);
                end
            end
        end
    end

    // Grant selection: uncontended FIFO goes straight through, contention
    // is resolved by the round-robin pointer.
    always_comb begin
        w_pop       = 2'b00;
        w_contended = w_run && !w_empty[0] && !w_empty[1];
        if (w_contended) begin
            w_pop = r_rr ? 2'b10 : 2'b01;
        end else if (w_run) begin
            w_pop = ~w_empty;
        end
    end

    assign w_grant_entry = w_pop[1] ? w_head[1] : w_head[0];

    // State register and clear counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR_EN ? S_CLEAR : S_RUN;
            r_clr_cnt <= 5'd1;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 5'd1;
            end
        end
    end

    // Next state and state-derived handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_a_ready    = 1'b0;
        w_b_ready    = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_busy = 1'b1;
                if (r_clr_cnt == 5'd31) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_a_ready = !w_full[0];
                w_b_ready = !w_full[1];
            end
            default: w_state_next = S_RUN;
        endcase
    end

    // Round-robin pointer moves only when both FIFOs competed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= 1'b0;
        end else if (w_contended) begin
            r_rr <= ~r_rr;
        end
    end

    // Registered write port: clear writes, granted entries, or idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= 32'd0;
        end else if (r_state == S_CLEAR) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= r_clr_cnt;
            r_rf_wdata <= 32'd0;
        end else if (|w_pop) begin
            // Writes to $zero are consumed but never enabled.
            r_rf_we    <= (w_grant_entry[36:32] != 5'd0);
            r_rf_waddr <= w_grant_entry[36:32];
            r_rf_wdata <= w_grant_entry[31:0];
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

    assign bus.a_ready  = w_a_ready;
    assign bus.b_ready  = w_b_ready;
    assign bus.busy     = w_busy;
    assign bus.pending  = !w_empty[0] || !w_empty[1];
    assign bus.rf_we    = r_rf_we;
    assign bus.rf_waddr = r_rf_waddr;
    assign bus.rf_wdata = r_rf_wdata;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter (DEPTH=2, CLEAR_EN=1). A queue-based model
// of the arbiter predicts ready/busy/pending and the write port cycle by
// cycle; directed scenarios also check fixed expected values.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    regfile_write_arbiter_if bus_if ();

    regfile_write_arbiter #(.DEPTH(DEPTH), .CLEAR_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [36:0] mq_a[$];
    logic [36:0] mq_b[$];
    bit          m_rr    = 1'b0;   // 1 = B wins the next contended grant
    int          m_cnt   = 1;      // clear register to write next; 0 = running
    logic        m_we    = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;

    function automatic logic exp_a_ready();
        return (m_cnt == 0) && (mq_a.size() < DEPTH);
    endfunction
    function automatic logic exp_b_ready();
        return (m_cnt == 0) && (mq_b.size() < DEPTH);
    endfunction
    function automatic logic exp_pending();
        return (mq_a.size() > 0) || (mq_b.size() > 0);
    endfunction
    function automatic logic exp_busy();
        return (m_cnt != 0);
    endfunction

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        logic        pa, pb;
        logic [36:0] e;
        int          sel;
        if (rst) begin
            mq_a.delete(); mq_b.delete();
            m_rr = 1'b0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = 1;
            return;
        end
        if (m_cnt != 0) begin
            m_we = 1'b1; m_waddr = 5'(m_cnt); m_wdata = '0;
            m_cnt = (m_cnt == 31) ? 0 : m_cnt + 1;
            return;
        end
        pa  = bus_if.a_valid && exp_a_ready();
        pb  = bus_if.b_valid && exp_b_ready();
        sel = -1;
        if (mq_a.size() > 0 && mq_b.size() > 0) begin
            sel  = m_rr ? 1 : 0;
            m_rr = !m_rr;
        end else if (mq_a.size() > 0) sel = 0;
        else if (mq_b.size() > 0) sel = 1;
        if (sel >= 0) begin
            e = (sel == 0) ? mq_a.pop_front() : mq_b.pop_front();
            m_we = (e[36:32] != 0); m_waddr = e[36:32]; m_wdata = e[31:0];
        end else begin
            m_we = 1'b0;
        end
        if (pa) mq_a.push_back({bus_if.a_reg, bus_if.a_data});
        if (pb) mq_b.push_back({bus_if.b_reg, bus_if.b_data});
    endtask

    // One clock: model step, edge, settle; print one line per issued write.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        if (bus_if.rf_we === 1'b1)
            $display("cyc %0d: write r%0d = 0x%08h", cyc, bus_if.rf_waddr, bus_if.rf_wdata);
    endtask

    task automatic idle_inputs();
        bus_if.a_valid = 1'b0; bus_if.a_reg = '0; bus_if.a_data = '0;
        bus_if.b_valid = 1'b0; bus_if.b_reg = '0; bus_if.b_data = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++; if (bus_if.rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", bus_if.rf_we); end
        checks++; if (bus_if.rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", bus_if.rf_waddr); end
        checks++; if (bus_if.rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", bus_if.rf_wdata); end
        checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", bus_if.busy); end
        checks++; if (bus_if.pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", bus_if.pending); end
    endtask

    task automatic test_clear(input string tag);
        for (int i = 1; i <= 31; i++) begin
            checks++;
            if (bus_if.busy !== 1'b1 || bus_if.a_ready !== 1'b0 || bus_if.b_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_status step=%0d busy=%b a_rdy=%b b_rdy=%b exp busy=1 rdy=0",
                         tag, i, bus_if.busy, bus_if.a_ready, bus_if.b_ready);
            end
            cycle();
            checks++;
            if (bus_if.rf_we !== 1'b1 || bus_if.rf_waddr !== 5'(i) || bus_if.rf_wdata !== 32'd0) begin
                errors++;
                $display("FAIL %s_write step=%0d got we=%b addr=%0d data=%h exp we=1 addr=%0d data=0",
                         tag, i, bus_if.rf_we, bus_if.rf_waddr, bus_if.rf_wdata, i);
            end
        end
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.a_ready !== 1'b1 || bus_if.b_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_done busy=%b a_rdy=%b b_rdy=%b exp busy=0 rdy=1",
                     tag, bus_if.busy, bus_if.a_ready, bus_if.b_ready);
        end
    endtask

    task automatic test_single_write();
        bus_if.a_valid = 1'b1; bus_if.a_reg = 5'd8; bus_if.a_data = 32'hDEADBEEF;
        cycle();
        idle_inputs();
        checks++; if (bus_if.pending !== 1'b1 || bus_if.rf_we !== 1'b0) begin
            errors++; $display("FAIL single_queued pending=%b we=%b exp pending=1 we=0", bus_if.pending, bus_if.rf_we); end
        cycle();
        checks++; if (bus_if.rf_we !== 1'b1 || bus_if.rf_waddr !== 5'd8 || bus_if.rf_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_write got we=%b addr=%0d data=%h exp we=1 addr=8 data=deadbeef",
                               bus_if.rf_we, bus_if.rf_waddr, bus_if.rf_wdata); end
        checks++; if (bus_if.pending !== 1'b0) begin errors++; $display("FAIL single_pending got=%b exp=0", bus_if.pending); end
        cycle();
        checks++; if (bus_if.rf_we !== 1'b0 || bus_if.rf_waddr !== 5'd8) begin
            errors++; $display("FAIL single_idle got we=%b addr=%0d exp we=0 addr=8", bus_if.rf_we, bus_if.rf_waddr); end
    endtask

    task automatic test_contention();
        logic [4:0]  exp_addr [4];
        logic [31:0] exp_data [4];
        exp_addr = '{5'd5, 5'd6, 5'd5, 5'd6};
        exp_data = '{32'h11, 32'h22, 32'h33, 32'h44};
        bus_if.a_valid = 1'b1; bus_if.a_reg = 5'd5; bus_if.a_data = 32'h11;
        bus_if.b_valid = 1'b1; bus_if.b_reg = 5'd6; bus_if.b_data = 32'h22;
        cycle();
        bus_if.a_data = 32'h33; bus_if.b_data = 32'h44;
        cycle();
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cycle();
            checks++;
            if (bus_if.rf_we !== 1'b1 || bus_if.rf_waddr !== exp_addr[k] || bus_if.rf_wdata !== exp_data[k]) begin
                errors++;
                $display("FAIL rr_order slot=%0d got we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h",
                         k, bus_if.rf_we, bus_if.rf_waddr, bus_if.rf_wdata, exp_addr[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_full_backpressure();
        logic [31:0] a_dat [3];
        int a_idx = 0, b_cnt = 0, a_seen = 0, stalls = 0;
        logic ra, rb;
        for (int i = 0; i < 3; i++) a_dat[i] = $urandom;
        for (int c = 0; c < 40; c++) begin
            bus_if.a_valid = (a_idx < 3);
            bus_if.a_reg   = 5'(10 + (a_idx < 3 ? a_idx : 0));
            bus_if.a_data  = a_dat[a_idx < 3 ? a_idx : 0];
            bus_if.b_valid = (b_cnt < 8);
            bus_if.b_reg   = 5'($urandom_range(20, 27));
            bus_if.b_data  = $urandom;
            ra = exp_a_ready(); rb = exp_b_ready();
            checks++;
            if (bus_if.a_ready !== ra || bus_if.b_ready !== rb || bus_if.pending !== exp_pending()) begin
                errors++;
                $display("FAIL full_status c=%0d got a_rdy=%b b_rdy=%b pend=%b exp %b %b %b",
                         c, bus_if.a_ready, bus_if.b_ready, bus_if.pending, ra, rb, exp_pending());
            end
            if (bus_if.a_valid && bus_if.a_ready === 1'b0) stalls++;
            if (bus_if.a_valid && ra) a_idx++;
            if (bus_if.b_valid && rb) b_cnt++;
            cycle();
            checks++;
            if (bus_if.rf_we !== m_we || (m_we && (bus_if.rf_waddr !== m_waddr || bus_if.rf_wdata !== m_wdata))) begin
                errors++;
                $display("FAIL full_write c=%0d got we=%b addr=%0d data=%h exp we=%b addr=%0d data=%h",
                         c, bus_if.rf_we, bus_if.rf_waddr, bus_if.rf_wdata, m_we, m_waddr, m_wdata);
            end
            if (bus_if.rf_we === 1'b1 && bus_if.rf_waddr >= 5'd10 && bus_if.rf_waddr <= 5'd12) begin
                checks++;
                if (a_seen > 2 || bus_if.rf_waddr !== 5'(10 + a_seen) || bus_if.rf_wdata !== a_dat[a_seen > 2 ? 0 : a_seen]) begin
                    errors++;
                    $display("FAIL full_a_order n=%0d got addr=%0d data=%h exp addr=%0d",
                             a_seen, bus_if.rf_waddr, bus_if.rf_wdata, 10 + a_seen);
                end
                a_seen++;
            end
        end
        idle_inputs();
        checks++; if (a_seen !== 3) begin errors++; $display("FAIL full_a_count got=%0d exp=3", a_seen); end
        checks++; if (stalls == 0) begin errors++; $display("FAIL full_stall got=0 stall cycles exp>0"); end
    endtask

    task automatic test_reg_zero();
        bus_if.a_valid = 1'b1; bus_if.a_reg = 5'd0; bus_if.a_data = 32'hFFFFFFFF;
        cycle();
        bus_if.a_reg = 5'd3; bus_if.a_data = 32'd7;
        cycle();
        idle_inputs();
        checks++; if (bus_if.rf_we !== 1'b0) begin errors++; $display("FAIL zero_we got=%b exp=0", bus_if.rf_we); end
        cycle();
        checks++; if (bus_if.rf_we !== 1'b1 || bus_if.rf_waddr !== 5'd3 || bus_if.rf_wdata !== 32'd7) begin
            errors++; $display("FAIL zero_next got we=%b addr=%0d data=%h exp we=1 addr=3 data=7",
                               bus_if.rf_we, bus_if.rf_waddr, bus_if.rf_wdata); end
        cycle();
    endtask

    task automatic test_random();
        logic ra, rb;
        for (int c = 0; c < 250; c++) begin
            bus_if.a_valid = ($urandom_range(0, 99) < 55);
            bus_if.a_reg   = 5'($urandom_range(0, 31));
            bus_if.a_data  = $urandom;
            bus_if.b_valid = ($urandom_range(0, 99) < 55);
            bus_if.b_reg   = 5'($urandom_range(0, 31));
            bus_if.b_data  = $urandom;
            ra = exp_a_ready(); rb = exp_b_ready();
            checks++;
            if (bus_if.a_ready !== ra || bus_if.b_ready !== rb || bus_if.pending !== exp_pending() ||
                bus_if.busy !== exp_busy()) begin
                errors++;
                $display("FAIL rand_status c=%0d got a=%b b=%b pend=%b busy=%b exp %b %b %b %b",
                         c, bus_if.a_ready, bus_if.b_ready, bus_if.pending, bus_if.busy,
                         ra, rb, exp_pending(), exp_busy());
            end
            cycle();
            checks++;
            if (bus_if.rf_we !== m_we || bus_if.rf_waddr !== m_waddr || bus_if.rf_wdata !== m_wdata) begin
                errors++;
                $display("FAIL rand_write c=%0d got we=%b addr=%0d data=%h exp we=%b addr=%0d data=%h",
                         c, bus_if.rf_we, bus_if.rf_waddr, bus_if.rf_wdata, m_we, m_waddr, m_wdata);
            end
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) cycle();
    endtask

    task automatic test_reset_mid();
        int leaked = 0;
        // Steer round-robin toward B so A's entries stay queued.
        if (!m_rr) begin
            bus_if.a_valid = 1'b1; bus_if.b_valid = 1'b1;
            cycle();
            idle_inputs();
            for (int c = 0; c < 3; c++) cycle();
        end
        bus_if.a_valid = 1'b1; bus_if.a_reg = 5'd13; bus_if.a_data = 32'hA0A0_0013;
        bus_if.b_valid = 1'b1; bus_if.b_reg = 5'd0;  bus_if.b_data = 32'h0;
        cycle();
        bus_if.a_reg = 5'd14; bus_if.a_data = 32'hA0A0_0014; bus_if.b_valid = 1'b0;
        cycle();
        idle_inputs();
        checks++; if (bus_if.rf_we !== 1'b0 || bus_if.pending !== 1'b1) begin
            errors++; $display("FAIL mid_queued got we=%b pend=%b exp we=0 pend=1", bus_if.rf_we, bus_if.pending); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++; if (bus_if.rf_we !== 1'b0 || bus_if.busy !== 1'b1 || bus_if.pending !== 1'b0) begin
            errors++; $display("FAIL mid_reset got we=%b busy=%b pend=%b exp we=0 busy=1 pend=0",
                               bus_if.rf_we, bus_if.busy, bus_if.pending); end
        test_clear("mid_clear");
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (bus_if.rf_we === 1'b1) leaked++;
        end
        checks++; if (leaked != 0) begin errors++; $display("FAIL mid_discard got=%0d writes exp=0", leaked); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_clear("clear");
        test_single_write();
        test_contention();
        test_full_backpressure();
        test_reg_zero();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
